uart_cmd_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_rx_byte.sv | 183 ++++++++++++++++++
 rtl/uart_cmd_rx.sv | 160 ++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg
// Shared types and constants for the UART command receiver slice.
//   - Receiver and parser state enums.
//   - Oversampling ratio and start-bit sample point.
//   - Command frame layout: address marker bit, payload width, data width.
// Optional build macro UART_CMD_RX_PARITY_EN adds the R_PARITY receiver state.
// ============================================================================
package uart_pkg;

    localparam int OVERSAMPLE   = 16;
    localparam int SAMPLE_POINT = 8;
    localparam int ADDR_MARKER  = 7;
    localparam int PAYLOAD_W    = 7;
    localparam int DATA_W       = 14;

    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP,
        R_WAIT
`ifdef UART_CMD_RX_PARITY_EN
        , R_PARITY
`endif
    } rx_state_t;

    typedef enum logic [1:0] {
        P_ADDR,
        P_HI,
        P_LO
    } parse_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// ============================================================================
// uart_rx_byte
// Byte receiver: 2-flop RX synchroniser, 16x oversample tick divider and the
// start/data/stop receiver FSM.
// Ports:
//   clk, reset_n  : system clock, synchronous active-low reset
//   i_rx          : asynchronous serial line, idle high
//   o_tick        : oversample tick (1/16 bit time), shared with the parser
//   o_byteValid   : one-cycle pulse per good byte
//   o_byteData    : last good byte
//   o_frameErr    : one-cycle pulse on bad stop bit (or parity error)
// Build macro UART_CMD_RX_PARITY_EN selects 8E1 framing instead of 8N1.
// ============================================================================
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_FREQUENCY = 50000000,
    parameter int BAUD_RATE     = 57600
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_rx,
    output logic       o_tick,
    output logic       o_byteValid,
    output logic [7:0] o_byteData,
    output logic       o_frameErr
);

    localparam int DIV_RAW = CLK_FREQUENCY / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

    logic             r_rxMeta;
    logic             r_rxs;
    logic             r_rxPrev;
    logic [1:0]       r_settle;
    logic [DIV_W-1:0] r_divCnt;
    rx_state_t        r_state;
    rx_state_t        w_nextState;
    logic [3:0]       r_tickCnt;
    logic [2:0]       r_bitCnt;
    logic [7:0]       r_shift;
    logic             r_byteValid;
    logic [7:0]       r_byteData;
    logic             r_frameErr;
    logic             w_tick;
    logic             w_fall;
    logic             w_sampleDue;
    logic             w_parityBad;
    logic             w_shiftIn;
    logic             w_goodByte;
    logic             w_badFrame;

    // Synchroniser plus edge-detect history. r_settle holds off edge
    // detection until both flops and r_rxPrev carry real line values, so a
    // line that is already low when reset releases never looks like a start.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rxMeta <= 1'b1;
            r_rxs    <= 1'b1;
            r_rxPrev <= 1'b1;
            r_settle <= 2'd0;
        end else begin
            r_rxMeta <= i_rx;
            r_rxs    <= r_rxMeta;
            r_rxPrev <= r_rxs;
            if (r_settle != 2'd3) begin
                r_settle <= r_settle + 2'd1;
            end
        end
    end

    assign w_fall = (r_settle == 2'd3) && r_rxPrev && !r_rxs;

    // Free-running divider producing the oversample tick.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_divCnt <= '0;
        end else if (r_divCnt == DIV_W'(DIV - 1)) begin
            r_divCnt <= '0;
        end else begin
            r_divCnt <= r_divCnt + DIV_W'(1);
        end
    end

    assign w_tick = (r_divCnt == DIV_W'(DIV - 1));
    assign o_tick = w_tick;

    // Start bit is checked half a bit in; every later sample is a full bit on.
    assign w_sampleDue = w_tick &&
        (r_tickCnt == ((r_state == R_START) ? 4'(SAMPLE_POINT - 1) : 4'(OVERSAMPLE - 1)));

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Receiver next-state logic.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            R_IDLE:  if (w_fall) w_nextState = R_START;
            R_START: if (w_sampleDue) w_nextState = r_rxs ? R_IDLE : R_DATA;
`ifdef UART_CMD_RX_PARITY_EN
            R_DATA:   if (w_sampleDue && r_bitCnt == 3'd7) w_nextState = R_PARITY;
            R_PARITY: if (w_sampleDue) w_nextState = R_STOP;
`else
            R_DATA:  if (w_sampleDue && r_bitCnt == 3'd7) w_nextState = R_STOP;
`endif
            R_STOP:  if (w_sampleDue) w_nextState = r_rxs ? R_IDLE : R_WAIT;
            R_WAIT:  if (r_rxs) w_nextState = R_IDLE;
            default: w_nextState = R_IDLE;
        endcase
    end

    // Receiver control decodes.
    always_comb begin
        w_shiftIn  = (r_state == R_DATA) && w_sampleDue;
        w_goodByte = (r_state == R_STOP) && w_sampleDue && r_rxs && !w_parityBad;
        w_badFrame = (r_state == R_STOP) && w_sampleDue && (!r_rxs || w_parityBad);
    end

`ifdef UART_CMD_RX_PARITY_EN
    logic r_parityErr;

    // Even parity: data bits plus parity bit must XOR to zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_parityErr <= 1'b0;
        end else if (r_state == R_START) begin
            r_parityErr <= 1'b0;
        end else if (r_state == R_PARITY && w_sampleDue) begin
            r_parityErr <= ^{r_shift, r_rxs};
        end
    end

    assign w_parityBad = r_parityErr;
`else
    assign w_parityBad = 1'b0;
`endif

    // Receiver datapath: oversample counter, bit counter, shifter, outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tickCnt   <= 4'd0;
            r_bitCnt    <= 3'd0;
            r_shift     <= 8'd0;
            r_byteValid <= 1'b0;
            r_byteData  <= 8'd0;
            r_frameErr  <= 1'b0;
        end else begin
            r_byteValid <= w_goodByte;
            r_frameErr  <= w_badFrame;
            if (w_goodByte) begin
                r_byteData <= r_shift;
            end
            if (r_state == R_IDLE || r_state == R_WAIT) begin
                r_tickCnt <= 4'd0;
            end else if (w_sampleDue) begin
                r_tickCnt <= 4'd0;
            end else if (w_tick) begin
                r_tickCnt <= r_tickCnt + 4'd1;
            end
            if (r_state == R_START) begin
                r_bitCnt <= 3'd0;
            end else if (w_shiftIn) begin
                r_bitCnt <= r_bitCnt + 3'd1;
            end
            if (w_shiftIn) begin
                r_shift <= {r_rxs, r_shift[7:1]};
            end
        end
    end

    assign o_byteValid = r_byteValid;
    assign o_byteData  = r_byteData;
    assign o_frameErr  = r_frameErr;

endmodule

// File: rtl/uart_cmd_rx.sv
// ============================================================================
// uart_cmd_rx
// Host command receiver: turns 3-byte frames {addr|0x80, hi7, lo7} arriving on
// RX into single-cycle register write strobes.
// Ports:
//   clk, reset_n : system clock, synchronous active-low reset
//   RX           : asynchronous serial input, idle high
//   byte_valid   : one-cycle pulse per good byte, byte_data holds it
//   reg_wr       : one-cycle write strobe with reg_addr / reg_data (held)
//   frame_err    : one-cycle pulse on bad stop bit (or parity error)
//   cmd_err      : one-cycle pulse on protocol error, bad address, timeout
// Build macro UART_CMD_RX_PARITY_EN selects 8E1 framing instead of 8N1.
// ============================================================================
module uart_cmd_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQUENCY = 50000000,
    parameter int BAUD_RATE     = 57600,
    parameter int NUM_REGS      = 64,
    parameter int TIMEOUT_BITS  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              RX,
    output logic              byte_valid,
    output logic [7:0]        byte_data,
    output logic              reg_wr,
    output logic [6:0]        reg_addr,
    output logic [DATA_W-1:0] reg_data,
    output logic              frame_err,
    output logic              cmd_err
);

    localparam int TIMEOUT_TICKS = TIMEOUT_BITS * OVERSAMPLE;
    localparam int TO_W          = $clog2(TIMEOUT_TICKS + 1);

    logic                 w_tick;
    logic                 w_byteValid;
    logic [7:0]           w_byteData;
    logic                 w_frameErr;
    parse_state_t         r_pState;
    parse_state_t         w_pNext;
    logic [6:0]           r_addrLatch;
    logic [PAYLOAD_W-1:0] r_hiLatch;
    logic [TO_W-1:0]      r_toCnt;
    logic                 r_regWr;
    logic [6:0]           r_regAddr;
    logic [DATA_W-1:0]    r_regData;
    logic                 r_cmdErr;
    logic                 w_isAddr;
    logic                 w_timeout;
    logic                 w_dataByte;
    logic                 w_lowByte;
    logic                 w_inRange;
    logic                 w_wrStrobe;
    logic                 w_cmdErr;

    uart_rx_byte #(
        .CLK_FREQUENCY (CLK_FREQUENCY),
        .BAUD_RATE     (BAUD_RATE)
    ) u_rxByte (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_rx        (RX),
        .o_tick      (w_tick),
        .o_byteValid (w_byteValid),
        .o_byteData  (w_byteData),
        .o_frameErr  (w_frameErr)
    );

    assign w_isAddr   = w_byteData[ADDR_MARKER];
    assign w_dataByte = w_byteValid && !w_isAddr;
    assign w_timeout  = (r_pState != P_ADDR) && w_tick &&
                        (r_toCnt == TO_W'(TIMEOUT_TICKS - 1));
    assign w_inRange  = (int'(r_addrLatch) < NUM_REGS);

    // Partial-frame timeout, counted in oversample ticks.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_toCnt <= '0;
        end else if (r_pState == P_ADDR || w_byteValid) begin
            r_toCnt <= '0;
        end else if (w_tick) begin
            r_toCnt <= r_toCnt + TO_W'(1);
        end
    end

    // Parser state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pState <= P_ADDR;
        end else begin
            r_pState <= w_pNext;
        end
    end

    // Parser next state. A frame error outranks everything, including a
    // timeout landing in the same cycle; an address byte always resyncs.
    always_comb begin
        w_pNext = r_pState;
        if (w_frameErr) begin
            w_pNext = P_ADDR;
        end else if (w_byteValid) begin
            if (w_isAddr) begin
                w_pNext = P_HI;
            end else begin
                case (r_pState)
                    P_HI:    w_pNext = P_LO;
                    default: w_pNext = P_ADDR;
                endcase
            end
        end else if (w_timeout) begin
            w_pNext = P_ADDR;
        end
    end

    // Parser output decodes.
    always_comb begin
        w_lowByte  = !w_frameErr && w_dataByte && (r_pState == P_LO);
        w_wrStrobe = w_lowByte && w_inRange;
        w_cmdErr   = !w_frameErr &&
                     ((w_dataByte && r_pState == P_ADDR) ||
                      (w_lowByte && !w_inRange) ||
                      (!w_byteValid && w_timeout));
    end

    // Parser datapath: frame latches and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_addrLatch <= 7'd0;
            r_hiLatch   <= '0;
            r_regWr     <= 1'b0;
            r_regAddr   <= 7'd0;
            r_regData   <= '0;
            r_cmdErr    <= 1'b0;
        end else begin
            r_regWr  <= w_wrStrobe;
            r_cmdErr <= w_cmdErr;
            if (!w_frameErr && w_byteValid && w_isAddr) begin
                r_addrLatch <= w_byteData[6:0];
            end
            if (!w_frameErr && w_dataByte && r_pState == P_HI) begin
                r_hiLatch <= w_byteData[PAYLOAD_W-1:0];
            end
            if (w_wrStrobe) begin
                r_regAddr <= r_addrLatch;
                r_regData <= {r_hiLatch, w_byteData[PAYLOAD_W-1:0]};
            end
        end
    end

    assign byte_valid = w_byteValid;
    assign byte_data  = w_byteData;
    assign frame_err  = w_frameErr;
    assign reg_wr     = r_regWr;
    assign reg_addr   = r_regAddr;
    assign reg_data   = r_regData;
    assign cmd_err    = r_cmdErr;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// ============================================================================
// tb_uart_cmd_rx
// Self-checking bench for uart_cmd_rx at 16 clocks per bit.
// Table of 3-byte frames with expected write/error results, plus hand-written
// sequences for resync, break, glitch, timeout and mid-byte reset.
// ============================================================================
module tb_uart_cmd_rx;

    localparam int BIT_CLKS = 16;
`ifdef UART_CMD_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    // Third byte start to reg_wr: stop centre (~9.5 bits) + sync delay + 2.
    localparam int LAT_LO = 153 + PAR_BITS * BIT_CLKS;
    localparam int LAT_HI = 160 + PAR_BITS * BIT_CLKS;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        RX;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        reg_wr;
    logic [6:0]  reg_addr;
    logic [13:0] reg_data;
    logic        frame_err;
    logic        cmd_err;

    uart_cmd_rx #(
        .CLK_FREQUENCY (1600000),
        .BAUD_RATE     (100000),
        .NUM_REGS      (64),
        .TIMEOUT_BITS  (32)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .RX         (RX),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .reg_wr     (reg_wr),
        .reg_addr   (reg_addr),
        .reg_data   (reg_data),
        .frame_err  (frame_err),
        .cmd_err    (cmd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        int          expWr;
        logic [6:0]  expAddr;
        logic [13:0] expData;
        int          expCmdErr;
    } vec_t;

    localparam int NUM_VECS = 5;
    vec_t vecs [NUM_VECS];

    int compared   = 0;
    int mismatched = 0;
    int cycleCount = 0;
    int bvCount    = 0;
    int wrCount    = 0;
    int ceCount    = 0;
    int feCount    = 0;
    int lastWrCycle = 0;
    int lastStart  = 0;
    int baseBv, baseWr, baseCe, baseFe;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (byte_valid === 1'b1) bvCount++;
        if (frame_err === 1'b1)  feCount++;
        if (cmd_err === 1'b1)    ceCount++;
        if (reg_wr === 1'b1) begin
            wrCount++;
            lastWrCycle = cycleCount;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkWindow(input string name, input int actual, input int lo, input int hi);
        compared++;
        if (actual < lo || actual > hi) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic takeSnapshot();
        baseBv = bvCount;
        baseWr = wrCount;
        baseCe = ceCount;
        baseFe = feCount;
    endtask

    task automatic idleBits(input int n);
        RX = 1'b1;
        repeat (n * BIT_CLKS) @(negedge clk);
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stopBit);
        @(negedge clk);
        RX = 1'b0;
        lastStart = cycleCount;
        repeat (BIT_CLKS - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
`ifdef UART_CMD_RX_PARITY_EN
        RX = ^b;
        repeat (BIT_CLKS) @(negedge clk);
`endif
        RX = stopBit;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic applyStimulus(input vec_t v);
        sendByte(v.b0, 1'b1);
        sendByte(v.b1, 1'b1);
        sendByte(v.b2, 1'b1);
        idleBits(2);
    endtask

    initial begin
        vecs[0] = '{8'h85, 8'h12, 8'h34, 1, 7'd5,  14'h0934, 0};
        vecs[1] = '{8'hC8, 8'h00, 8'h01, 0, 7'd5,  14'h0934, 1};
        vecs[2] = '{8'hBF, 8'h7F, 8'h7F, 1, 7'd63, 14'h3FFF, 0};
        vecs[3] = '{8'hC0, 8'h01, 8'h02, 0, 7'd63, 14'h3FFF, 1};
        vecs[4] = '{8'h81, 8'h00, 8'h7F, 1, 7'd1,  14'h007F, 0};

        reset_n = 1'b0;
        RX      = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset strobes", {byte_valid, reg_wr, frame_err, cmd_err}, 4'b0000);
        checkOutput("reset byte_data", byte_data, 8'h00);
        checkOutput("reset reg_addr/data", {reg_addr, reg_data}, 21'd0);
        reset_n = 1'b1;
        idleBits(2);

        for (int v = 0; v < NUM_VECS; v++) begin
            takeSnapshot();
            applyStimulus(vecs[v]);
            checkOutput($sformatf("vec%0d reg_wr count", v), wrCount - baseWr, vecs[v].expWr);
            checkOutput($sformatf("vec%0d cmd_err count", v), ceCount - baseCe, vecs[v].expCmdErr);
            checkOutput($sformatf("vec%0d frame_err count", v), feCount - baseFe, 0);
            checkOutput($sformatf("vec%0d byte_valid count", v), bvCount - baseBv, 3);
            checkOutput($sformatf("vec%0d byte_data", v), byte_data, vecs[v].b2);
            checkOutput($sformatf("vec%0d reg_addr", v), reg_addr, vecs[v].expAddr);
            checkOutput($sformatf("vec%0d reg_data", v), reg_data, vecs[v].expData);
            if (vecs[v].expWr == 1) begin
                checkWindow($sformatf("vec%0d write latency", v), lastWrCycle - lastStart,
                            LAT_LO, LAT_HI);
            end
        end

        $display("[TB] resync on new address mid-frame");
        takeSnapshot();
        sendByte(8'h85, 1'b1);
        sendByte(8'h12, 1'b1);
        sendByte(8'h87, 1'b1);
        sendByte(8'h01, 1'b1);
        sendByte(8'h02, 1'b1);
        idleBits(2);
        checkOutput("resync reg_wr count", wrCount - baseWr, 1);
        checkOutput("resync reg_addr", reg_addr, 7'd7);
        checkOutput("resync reg_data", reg_data, 14'h0082);
        checkOutput("resync cmd_err count", ceCount - baseCe, 0);

        $display("[TB] lone data byte");
        takeSnapshot();
        sendByte(8'h11, 1'b1);
        idleBits(2);
        checkOutput("lone data cmd_err", ceCount - baseCe, 1);
        checkOutput("lone data reg_wr", wrCount - baseWr, 0);

        $display("[TB] bad stop bit then held break");
        takeSnapshot();
        sendByte(8'h55, 1'b0);
        repeat (100 * BIT_CLKS) @(negedge clk);
        checkOutput("break frame_err count", feCount - baseFe, 1);
        checkOutput("break byte_valid count", bvCount - baseBv, 0);
        checkOutput("break cmd_err count", ceCount - baseCe, 0);
        idleBits(2);
        takeSnapshot();
        sendByte(8'h81, 1'b1);
        sendByte(8'h00, 1'b1);
        sendByte(8'h7F, 1'b1);
        idleBits(2);
        checkOutput("post-break reg_wr count", wrCount - baseWr, 1);
        checkOutput("post-break reg_addr", reg_addr, 7'd1);
        checkOutput("post-break reg_data", reg_data, 14'h007F);

        $display("[TB] short glitch on idle line");
        takeSnapshot();
        @(negedge clk);
        RX = 1'b0;
        repeat (4) @(negedge clk);
        idleBits(3);
        checkOutput("glitch byte_valid", bvCount - baseBv, 0);
        checkOutput("glitch errors", (feCount - baseFe) + (ceCount - baseCe), 0);

        $display("[TB] partial frame timeout");
        takeSnapshot();
        sendByte(8'h82, 1'b1);
        sendByte(8'h01, 1'b1);
        idleBits(25);
        checkOutput("timeout early cmd_err", ceCount - baseCe, 0);
        idleBits(15);
        checkOutput("timeout cmd_err", ceCount - baseCe, 1);
        sendByte(8'h03, 1'b1);
        idleBits(2);
        checkOutput("timeout trailing cmd_err", ceCount - baseCe, 2);
        checkOutput("timeout reg_wr", wrCount - baseWr, 0);

        $display("[TB] reset in the middle of a byte");
        @(negedge clk);
        RX = 1'b0;
        repeat (50) @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("mid-byte reset outputs", {byte_valid, reg_wr, frame_err, cmd_err,
                    reg_addr, reg_data}, 25'd0);
        takeSnapshot();
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        idleBits(12);
        checkOutput("low-line release byte_valid", bvCount - baseBv, 0);
        checkOutput("low-line release frame_err", feCount - baseFe, 0);
        sendByte(8'h85, 1'b1);
        sendByte(8'h12, 1'b1);
        sendByte(8'h34, 1'b1);
        idleBits(2);
        checkOutput("post-reset reg_wr count", wrCount - baseWr, 1);
        checkOutput("post-reset reg_addr", reg_addr, 7'd5);
        checkOutput("post-reset reg_data", reg_data, 14'h0934);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
